// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor poll scheduler.
//   schedState_e   : round-robin FSM states
//   chW()          : channel index width for a given channel count
//   DEF_PERIOD_MS  : default ms between automatic rounds
//   DEF_TIMEOUT_MS : default ms allowed per channel response
package sensor_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    START,
    WAIT,
    NEXT
  } schedState_e;

  localparam int unsigned DEF_PERIOD_MS  = 1000;
  localparam int unsigned DEF_TIMEOUT_MS = 50;

  // Width of a channel index; never below one bit so a port can always be declared.
  function automatic int unsigned chW(input int unsigned numCh);
    return (numCh < 2) ? 1 : $clog2(numCh);
  endfunction

endpackage

// File: rtl/ch_next_find.sv
// Combinational search for the lowest set mask bit strictly above an index.
//   iMask    : candidate channels
//   iIdx     : search starts above this index
//   iFromLow : 1 = ignore iIdx and search from bit 0 (index "-1")
//   oIdx     : index of the channel found (0 when none)
//   oFound   : a channel was found
module ch_next_find
  import sensor_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH = 4,
  localparam int unsigned CH_W   = chW(NUM_CH)
) (
  input  logic [NUM_CH-1:0] iMask,
  input  logic [CH_W-1:0]   iIdx,
  input  logic              iFromLow,
  output logic [CH_W-1:0]   oIdx,
  output logic              oFound
);

  // Scan downwards so the last hit written is the lowest qualifying bit.
  always_comb begin
    oFound = 1'b0;
    oIdx   = '0;
    for (int n = NUM_CH - 1; n >= 0; n--) begin
      if (iMask[n] && (iFromLow || (n > int'(iIdx)))) begin
        oFound = 1'b1;
        oIdx   = CH_W'(n);
      end
    end
  end

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Round-robin poll scheduler for the sensor front-ends. Each enabled channel
// gets a start pulse in turn; the scheduler waits for its done pulse or a ms
// timeout, latches the result, then moves on to the next enabled channel.
//   iClk, iRst   : clock, asynchronous active-high reset
//   iMs_Tick     : one-cycle 1 ms strobe
//   iEn          : scheduler enable (also holds the period counter at 0 when low)
//   iCh_Mask     : channels included in rounds
//   iForce       : one-cycle manual round request
//   iDone, iData : per-channel result-ready pulse and result bus
//   oStart       : one-cycle start pulse per channel
//   oBusy        : round in progress
//   oData        : latched results, slice n = [n*DATA_W +: DATA_W]
//   oValid       : channel has latched at least one result
//   oTimeout     : last poll of the channel timed out
//   oCur_Ch      : channel currently being polled
//   oRound_Done  : one-cycle pulse at round end
module sensor_poll_scheduler
  import sensor_sched_pkg::*;
#(
  parameter  int unsigned NUM_CH     = 4,
  parameter  int unsigned DATA_W     = 32,
  parameter  int unsigned PERIOD_MS  = DEF_PERIOD_MS,
  parameter  int unsigned TIMEOUT_MS = DEF_TIMEOUT_MS,
  localparam int unsigned CH_W       = chW(NUM_CH)
) (
  input  logic                     iClk,
  input  logic                     iRst,
  input  logic                     iMs_Tick,
  input  logic                     iEn,
  input  logic [NUM_CH-1:0]        iCh_Mask,
  input  logic                     iForce,
  input  logic [NUM_CH-1:0]        iDone,
  input  logic [NUM_CH*DATA_W-1:0] iData,
  output logic [NUM_CH-1:0]        oStart,
  output logic                     oBusy,
  output logic [NUM_CH*DATA_W-1:0] oData,
  output logic [NUM_CH-1:0]        oValid,
  output logic [NUM_CH-1:0]        oTimeout,
  output logic [CH_W-1:0]          oCur_Ch,
  output logic                     oRound_Done
);

  localparam int unsigned PCNT_W = $clog2(PERIOD_MS);
  localparam int unsigned TCNT_W = $clog2(TIMEOUT_MS + 1);
  localparam logic [NUM_CH-1:0] ONE_CH = NUM_CH'(1);

  schedState_e       state;
  logic [PCNT_W-1:0] periodCnt;
  logic [TCNT_W-1:0] toCnt;
  logic              pending;
  logic              trigger;
  logic              request;
  logic [CH_W-1:0]   findIdx;
  logic              findFound;

  assign trigger = iEn && iMs_Tick && (periodCnt == PCNT_W'(PERIOD_MS - 1));
  assign request = trigger || iForce;
  assign oBusy   = (state != IDLE);

  // Period counter keeps running during rounds so the cadence is independent of
  // how long a round takes; it restarts from 0 whenever the scheduler is disabled.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      periodCnt <= '0;
    end else if (!iEn) begin
      periodCnt <= '0;
    end else if (iMs_Tick) begin
      periodCnt <= trigger ? '0 : periodCnt + 1'b1;
    end
  end

  // SELECT searches from bit 0, NEXT searches strictly above the current channel.
  ch_next_find #(
    .NUM_CH(NUM_CH)
  ) u_find (
    .iMask   (iCh_Mask),
    .iIdx    (oCur_Ch),
    .iFromLow(state == SELECT),
    .oIdx    (findIdx),
    .oFound  (findFound)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state       <= IDLE;
      toCnt       <= '0;
      pending     <= 1'b0;
      oStart      <= '0;
      oData       <= '0;
      oValid      <= '0;
      oTimeout    <= '0;
      oCur_Ch     <= '0;
      oRound_Done <= 1'b0;
    end else begin
      oStart      <= '0;
      oRound_Done <= 1'b0;
      if ((state != IDLE) && !iEn) begin
        // Abandon the round: no latch, no round-done, queued request dropped.
        state   <= IDLE;
        pending <= 1'b0;
      end else begin
        // One request may queue behind the running round.
        if ((state != IDLE) && request) begin
          pending <= 1'b1;
        end
        unique case (state)
          IDLE: begin
            if (iEn && (|iCh_Mask) && (request || pending)) begin
              state   <= SELECT;
              pending <= 1'b0;
            end
          end
          SELECT: begin
            if (findFound) begin
              oCur_Ch <= findIdx;
              oStart  <= ONE_CH << findIdx;
              state   <= START;
            end else begin
              state <= IDLE;
            end
          end
          START: begin
            toCnt <= '0;
            state <= WAIT;
          end
          WAIT: begin
            // Done takes priority over a coincident final timeout tick.
            if (iDone[oCur_Ch]) begin
              oData[oCur_Ch*DATA_W +: DATA_W] <= iData[oCur_Ch*DATA_W +: DATA_W];
              oValid[oCur_Ch]   <= 1'b1;
              oTimeout[oCur_Ch] <= 1'b0;
              state             <= NEXT;
            end else if (iMs_Tick) begin
              if (toCnt == TCNT_W'(TIMEOUT_MS - 1)) begin
                oTimeout[oCur_Ch] <= 1'b1;
                state             <= NEXT;
              end else begin
                toCnt <= toCnt + 1'b1;
              end
            end
          end
          NEXT: begin
            if (findFound) begin
              oCur_Ch <= findIdx;
              oStart  <= ONE_CH << findIdx;
              state   <= START;
            end else begin
              oRound_Done <= 1'b1;
              state       <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
module tb_sensor_poll_scheduler;

  logic         iClk = 1'b0;
  logic         iRst;
  logic         iMs_Tick;
  logic         iEn;
  logic [3:0]   iCh_Mask;
  logic         iForce;
  logic [3:0]   iDone;
  logic [127:0] iData;
  logic [3:0]   oStart;
  logic         oBusy;
  logic [127:0] oData;
  logic [3:0]   oValid;
  logic [3:0]   oTimeout;
  logic [1:0]   oCur_Ch;
  logic         oRound_Done;

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  sensor_poll_scheduler #(
    .NUM_CH    (4),
    .DATA_W    (32),
    .PERIOD_MS (100),
    .TIMEOUT_MS(50)
  ) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iMs_Tick   (iMs_Tick),
    .iEn        (iEn),
    .iCh_Mask   (iCh_Mask),
    .iForce     (iForce),
    .iDone      (iDone),
    .iData      (iData),
    .oStart     (oStart),
    .oBusy      (oBusy),
    .oData      (oData),
    .oValid     (oValid),
    .oTimeout   (oTimeout),
    .oCur_Ch    (oCur_Ch),
    .oRound_Done(oRound_Done)
  );

  task automatic cyc();
    @(posedge iClk);
    #1;
  endtask

  task automatic tick();
    iMs_Tick = 1'b1;
    cyc();
    iMs_Tick = 1'b0;
    cyc();
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ms ticks of silence, then a one-cycle done pulse carrying val.
  task automatic respond(input int ch, input int ms, input logic [31:0] val);
    repeat (ms) tick();
    iData[ch*32 +: 32] = val;
    iDone = 4'(1) << ch;
    cyc();
    iDone = '0;
  endtask

  initial begin
    iRst = 1'b1; iMs_Tick = 1'b0; iEn = 1'b0; iForce = 1'b0;
    iCh_Mask = '0; iDone = '0; iData = '0;
    repeat (3) cyc();
    chk("rst_start", oStart, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_data", oData, 0);
    chk("rst_valid", oValid, 0);
    chk("rst_timeout", oTimeout, 0);
    chk("rst_cur", oCur_Ch, 0);
    chk("rst_rdone", oRound_Done, 0);
    iRst = 1'b0;
    cyc();

    // Round over mask 1011 started by iForce; ch2 must be skipped.
    iData[64 +: 32] = 32'hCAFE0002;
    iEn = 1'b1; iCh_Mask = 4'b1011; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    chk("sel_busy", oBusy, 1);
    chk("sel_nostart", oStart, 0);
    cyc();
    chk("start_ch0", oStart, 4'b0001);
    chk("cur_ch0", oCur_Ch, 0);
    cyc();
    chk("start_one_cycle", oStart, 0);
    respond(0, 3, 32'h12345678);
    chk("data_ch0", oData[31:0], 32'h12345678);
    chk("valid_ch0", oValid, 4'b0001);
    cyc();
    chk("start_ch1", oStart, 4'b0010);
    chk("cur_ch1", oCur_Ch, 1);
    cyc();
    respond(1, 5, 32'hAABBCCDD);
    cyc();
    chk("start_ch3_skip2", oStart, 4'b1000);
    chk("cur_ch3", oCur_Ch, 3);
    cyc();
    respond(3, 1, 32'h0F0F0F0F);
    chk("rdone_not_early", oRound_Done, 0);
    cyc();
    chk("rdone", oRound_Done, 1);
    chk("idle_after_round", oBusy, 0);
    cyc();
    chk("rdone_pulse", oRound_Done, 0);
    chk("valid_1011", oValid, 4'b1011);
    chk("data_all", oData, {32'h0F0F0F0F, 32'h0, 32'hAABBCCDD, 32'h12345678});
    iEn = 1'b0;
    cyc();

    // ch1 never answers: timeout after the 50th tick, data kept, round moves to ch2.
    iData[32 +: 32] = 32'h99999999;
    iEn = 1'b1; iCh_Mask = 4'b0110; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    cyc();
    chk("to_start_ch1", oStart, 4'b0010);
    cyc();
    repeat (49) tick();
    chk("to_not_yet", oTimeout, 0);
    chk("to_still_ch1", oCur_Ch, 1);
    chk("to_still_busy", oBusy, 1);
    iMs_Tick = 1'b1;
    cyc();
    iMs_Tick = 1'b0;
    chk("to_set", oTimeout, 4'b0010);
    chk("to_data_kept", oData[63:32], 32'hAABBCCDD);
    chk("to_valid_kept", oValid, 4'b1011);
    cyc();
    chk("to_next_ch2", oStart, 4'b0100);
    cyc();
    respond(2, 2, 32'h22222222);
    cyc();
    chk("to_rdone", oRound_Done, 1);
    iEn = 1'b0;
    cyc();

    // Foreign done ignored; done and final tick together; retry clears timeout.
    iEn = 1'b1; iCh_Mask = 4'b0011; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    cyc();
    chk("tie_start_ch0", oStart, 4'b0001);
    cyc();
    iData[64 +: 32] = 32'hDEADBEEF;
    iDone = 4'b0100;
    cyc();
    iDone = '0;
    chk("foreign_no_latch", oData[95:64], 32'h22222222);
    chk("foreign_cur", oCur_Ch, 0);
    repeat (49) tick();
    iData[0 +: 32] = 32'h0BADF00D;
    iDone = 4'b0001; iMs_Tick = 1'b1;
    cyc();
    iDone = '0; iMs_Tick = 1'b0;
    chk("tie_data", oData[31:0], 32'h0BADF00D);
    chk("tie_timeout", oTimeout, 4'b0010);
    cyc();
    chk("tie_start_ch1", oStart, 4'b0010);
    cyc();
    respond(1, 2, 32'h11111111);
    chk("retry_clears_to", oTimeout, 0);
    chk("retry_data", oData[63:32], 32'h11111111);
    cyc();
    chk("tie_rdone", oRound_Done, 1);
    iEn = 1'b0;
    cyc();

    // Periodic rounds every 100 ticks; iForce mid-round queues exactly one extra round.
    iEn = 1'b1; iCh_Mask = 4'b0001;
    repeat (99) tick();
    chk("per_no_early", oBusy, 0);
    iMs_Tick = 1'b1;
    cyc();
    iMs_Tick = 1'b0;
    chk("per_trigger", oBusy, 1);
    cyc();
    chk("per_start", oStart, 4'b0001);
    cyc();
    iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    respond(0, 1, 32'h00000001);
    cyc();
    chk("per_rdone", oRound_Done, 1);
    chk("per_idle", oBusy, 0);
    cyc();
    chk("extra_round", oBusy, 1);
    cyc();
    chk("extra_start", oStart, 4'b0001);
    cyc();
    respond(0, 1, 32'h00000002);
    cyc();
    chk("extra_rdone", oRound_Done, 1);
    cyc();
    chk("only_one_extra", oBusy, 0);
    repeat (97) tick();
    chk("per_gap", oBusy, 0);
    iMs_Tick = 1'b1;
    cyc();
    iMs_Tick = 1'b0;
    chk("per_second", oBusy, 1);
    cyc();
    cyc();
    respond(0, 1, 32'h00000003);
    cyc();
    chk("per_data", oData[31:0], 32'h00000003);
    iEn = 1'b0;
    cyc();

    // Mask 0 drops requests; iEn drop in WAIT abandons the round and the queue.
    iEn = 1'b1; iCh_Mask = 4'b0000; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    cyc();
    chk("mask0_dropped", oBusy, 0);
    iCh_Mask = 4'b0010; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    cyc();
    chk("en_start_ch1", oStart, 4'b0010);
    cyc();
    iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    iData[32 +: 32] = 32'h55555555;
    iDone = 4'b0010; iEn = 1'b0;
    cyc();
    iDone = '0;
    chk("endrop_idle", oBusy, 0);
    chk("endrop_no_rdone", oRound_Done, 0);
    chk("endrop_no_latch", oData[63:32], 32'h11111111);
    iEn = 1'b1;
    cyc();
    cyc();
    chk("endrop_pending_clr", oBusy, 0);
    iEn = 1'b0;
    cyc();

    // Asynchronous reset mid-round.
    iEn = 1'b1; iCh_Mask = 4'b1000; iForce = 1'b1;
    cyc();
    iForce = 1'b0;
    cyc();
    cyc();
    chk("pre_rst_cur", oCur_Ch, 3);
    iRst = 1'b1;
    #1;
    chk("arst_data", oData, 0);
    chk("arst_valid", oValid, 0);
    chk("arst_busy", oBusy, 0);
    chk("arst_cur", oCur_Ch, 0);
    chk("arst_start", oStart, 0);
    iRst = 1'b0; iEn = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
